// File: rtl/aes_pkg.sv
// Shared AES definitions for the inverse-cipher controller: sizes, FSM
// state type and the inverse S-box lookup.
package aes_pkg;

  localparam int NR_128  = 10;
  localparam int BLOCK_W = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } aes_state_e;

  // Inverse S-box, entry 0x00 in the top byte, entry 0xff in the bottom byte.
  localparam logic [2047:0] INV_SBOX_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [10:0] pos;
    pos = 11'd2047 - {b, 3'b000};
    return INV_SBOX_TBL[pos -: 8];
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One AES decryption round, purely combinational:
// InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns (skipped on
// the final round). Byte i of the block sits at bits [127-8i -: 8], with
// byte index = row + 4*column.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] i_state,
  input  logic [127:0] i_rk,
  input  logic         i_final,
  output logic [127:0] o_next
);

  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a 4-bit GF(2^8) constant (0x09, 0x0b, 0x0d, 0x0e).
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] a2, a4, a8;
    a2 = gf_xtime(a);
    a4 = gf_xtime(a2);
    a8 = gf_xtime(a4);
    return (k[0] ? a  : 8'h00) ^ (k[1] ? a2 : 8'h00) ^
           (k[2] ? a4 : 8'h00) ^ (k[3] ? a8 : 8'h00);
  endfunction

  logic [7:0] w_t [16];
  logic [7:0] w_m [16];

  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      // Row r is rotated right by r, so output column c reads column c-r.
      localparam int SRC = r + 4 * ((c + 4 - r) % 4);
      localparam int DST = r + 4 * c;
      assign w_t[DST] = inv_sbox(i_state[127 - 8*SRC -: 8]) ^ i_rk[127 - 8*DST -: 8];
    end

    assign w_m[4*c+0] = gf_mul(w_t[4*c+0], 4'he) ^ gf_mul(w_t[4*c+1], 4'hb) ^
                        gf_mul(w_t[4*c+2], 4'hd) ^ gf_mul(w_t[4*c+3], 4'h9);
    assign w_m[4*c+1] = gf_mul(w_t[4*c+0], 4'h9) ^ gf_mul(w_t[4*c+1], 4'he) ^
                        gf_mul(w_t[4*c+2], 4'hb) ^ gf_mul(w_t[4*c+3], 4'hd);
    assign w_m[4*c+2] = gf_mul(w_t[4*c+0], 4'hd) ^ gf_mul(w_t[4*c+1], 4'h9) ^
                        gf_mul(w_t[4*c+2], 4'he) ^ gf_mul(w_t[4*c+3], 4'hb);
    assign w_m[4*c+3] = gf_mul(w_t[4*c+0], 4'hb) ^ gf_mul(w_t[4*c+1], 4'hd) ^
                        gf_mul(w_t[4*c+2], 4'h9) ^ gf_mul(w_t[4*c+3], 4'he);

    assign o_next[127 - 32*c -: 32] = i_final ?
      {w_t[4*c+0], w_t[4*c+1], w_t[4*c+2], w_t[4*c+3]} :
      {w_m[4*c+0], w_m[4*c+1], w_m[4*c+2], w_m[4*c+3]};
  end

endmodule

// File: rtl/aes_inv_cipher_ctrl.sv
// Iterative AES inverse-cipher sequencer: one round per clock on a shared
// round datapath, round keys fetched by index from an external key store
// that answers combinationally in the same cycle.
module aes_inv_cipher_ctrl
  import aes_pkg::*;
#(
  parameter int NR = NR_128,
  parameter int DW = BLOCK_W
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DW-1:0]             in_data,
  output logic [$clog2(NR+1)-1:0]   rk_idx,
  input  logic [DW-1:0]             rk_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DW-1:0]             out_data,
  output logic                      busy
);

  localparam int RW = $clog2(NR + 1);

  aes_state_e      r_state;
  logic [DW-1:0]   r_data;
  logic [RW-1:0]   r_round;
  logic            r_out_valid;
  logic [DW-1:0]   r_out_data;
  logic [DW-1:0]   w_next;
  logic            w_final;

  assign w_final = (r_round == '0);

  aes_inv_round u_round (
    .i_state (r_data),
    .i_rk    (rk_data),
    .i_final (w_final),
    .o_next  (w_next)
  );

  // Key index follows the FSM: last key for the initial AddRoundKey, then the round counter.
  always_comb begin
    rk_idx = '0;
    case (r_state)
      IDLE:    rk_idx = RW'(NR);
      ROUND:   rk_idx = r_round;
      default: rk_idx = '0;
    endcase
  end

  // Gated by reset_n so the controller never advertises readiness while held in reset.
  assign in_ready  = reset_n && (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

  // Sequencer: accept a block, count rounds down to 0, hold the result until taken.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_data      <= '0;
      r_round     <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_data  <= in_data ^ rk_data;
            r_round <= RW'(NR - 1);
            r_state <= ROUND;
          end
        end
        ROUND: begin
          r_data <= w_next;
          if (!w_final) begin
            r_round <= r_round - RW'(1);
          end else begin
            r_out_data  <= w_next;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_cipher_ctrl.sv
// Bench for aes_inv_cipher_ctrl: key store model, byte-level AES inverse
// cipher reference, directed FIPS-197 vectors and randomized blocks.
module tb_aes_inv_cipher_ctrl;

  localparam int NR = 10;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic [3:0]   rk_idx;
  logic [127:0] rk_data;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] out_data;
  logic         busy;

  logic [127:0] rk_mem [11];
  logic [7:0]   sbox  [256];
  logic [7:0]   isbox [256];

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  always #5 clk = ~clk;

  assign rk_data = (rk_idx <= 4'd10) ? rk_mem[rk_idx] : '0;

  aes_inv_cipher_ctrl #(.NR(NR), .DW(128)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .rk_idx    (rk_idx),
    .rk_data   (rk_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  // S-box from its definition: multiplicative inverse then affine map.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      logic [7:0] s;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox[x]  = s;
      isbox[s] = 8'(x);
    end
  endtask

  task automatic load_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= NR; r++) rk_mem[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Textbook inverse cipher over a 16-byte array using the loaded key schedule.
  function automatic logic [127:0] ref_dec(input logic [127:0] ct);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] st;
    st = ct ^ rk_mem[NR];
    for (int rnd = NR - 1; rnd >= 0; rnd--) begin
      for (int i = 0; i < 16; i++) s[i] = st[127 - 8*i -: 8];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[r + 4*c] = isbox[s[r + 4*((c + 4 - r) % 4)]];
      for (int i = 0; i < 16; i++) st[127 - 8*i -: 8] = t[i];
      st = st ^ rk_mem[rnd];
      if (rnd > 0) begin
        for (int i = 0; i < 16; i++) s[i] = st[127 - 8*i -: 8];
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++)
            t[r + 4*c] = gm(s[4*c + r], 8'h0e) ^ gm(s[4*c + (r+1)%4], 8'h0b) ^
                         gm(s[4*c + (r+2)%4], 8'h0d) ^ gm(s[4*c + (r+3)%4], 8'h09);
        for (int i = 0; i < 16; i++) st[127 - 8*i -: 8] = t[i];
      end
    end
    return st;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Offer one block, follow it to out_valid; completes the output handshake when out_ready=1.
  task automatic run_block(input logic [127:0] ct, input logic [127:0] exp,
                           input string tag, input bit toggle);
    int          n;
    logic [39:0] seq;
    logic [39:0] seq_exp;
    logic        rdy_seen;
    seq_exp = 40'h9876543210;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    check({tag, "_in_ready"}, 128'(in_ready), 128'(1));
    check({tag, "_rk_idx_accept"}, 128'(rk_idx), 128'(10));
    in_data  = ct;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = rand128();
    seq = '0; n = 0; rdy_seen = 1'b0;
    while (!out_valid && n < 100) begin
      if (n < 10) seq = {seq[35:0], rk_idx};
      if (in_ready) rdy_seen = 1'b1;
      if (toggle) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = rand128();
      end
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    check({tag, "_latency"}, 128'(n), 128'(NR));
    check({tag, "_rk_seq"}, 128'(seq), 128'(seq_exp));
    check({tag, "_data"}, out_data, exp);
    if (toggle) check({tag, "_no_ready_in_round"}, 128'(rdy_seen), 128'(0));
    if (out_ready) begin
      @(posedge clk); #1;
      check({tag, "_out_valid_drop"}, 128'(out_valid), 128'(0));
      check({tag, "_idle_after"}, 128'(busy), 128'(0));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int           n;
    int           acc;
    int           got;
    int           cyc;
    int           acc_c [2];
    logic [127:0] outs  [2];
    logic [127:0] exp_z;
    logic [127:0] held;
    logic         stable;

    build_sbox();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_out_data", out_data, 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_in_ready", 128'(in_ready), 128'(0));
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("rel_in_ready", 128'(in_ready), 128'(1));

    // FIPS-197 C.1
    load_key(C1_KEY);
    run_block(C1_CT, C1_PT, "c1", 1'b0);

    // Zero key: model-derived and known-answer
    load_key('0);
    run_block('0, ref_dec('0), "zero", 1'b0);
    run_block(Z_CT, '0, "zero_kat", 1'b0);

    // Back-pressure for 20 cycles
    load_key(C1_KEY);
    out_ready = 1'b0;
    run_block(C1_CT, C1_PT, "bp", 1'b0);
    held = out_data;
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_data !== held || in_ready !== 1'b0) stable = 1'b0;
    end
    check("bp_stable", 128'(stable), 128'(1));
    check("bp_data_held", out_data, C1_PT);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", 128'(out_valid), 128'(0));
    check("bp_release_ready", 128'(in_ready), 128'(1));
    check("bp_data_kept", out_data, C1_PT);

    // Back-to-back with in_valid held high
    exp_z = ref_dec('0);
    @(negedge clk);
    in_data = C1_CT; in_valid = 1'b1;
    acc = 0; got = 0; cyc = 0;
    acc_c[0] = 0; acc_c[1] = 0; outs[0] = '0; outs[1] = '0;
    while ((acc < 2 || got < 2) && cyc < 100) begin
      if (out_valid && got < 2) begin outs[got] = out_data; got++; end
      if (in_valid && in_ready && acc < 2) begin acc_c[acc] = cyc; acc++; end
      @(posedge clk); #1;
      if (acc == 1) in_data = '0;
      if (acc == 2) in_valid = 1'b0;
      @(negedge clk);
      cyc++;
    end
    check("b2b_first", outs[0], C1_PT);
    check("b2b_second", outs[1], exp_z);
    check("b2b_spacing", 128'(acc_c[1] - acc_c[0]), 128'(NR + 2));

    // in_valid toggled during ROUND
    run_block(C1_CT, C1_PT, "toggle", 1'b1);

    // Reset while round_q == 5
    @(negedge clk);
    in_data = C1_CT; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (rk_idx != 4'd5 && n < 20) begin @(posedge clk); #1; n++; end
    check("mid_round5", 128'(rk_idx), 128'(5));
    reset_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 128'(out_valid), 128'(0));
    check("mid_rst_busy", 128'(busy), 128'(0));
    check("mid_rst_out_data", out_data, 128'(0));
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("mid_rel_in_ready", 128'(in_ready), 128'(1));
    run_block(C1_CT, C1_PT, "mid_fresh", 1'b0);

    // Randomized keys and ciphertexts
    for (int k = 0; k < 4; k++) begin
      load_key(rand128());
      for (int b = 0; b < 2; b++) begin
        logic [127:0] ct;
        ct = rand128();
        run_block(ct, ref_dec(ct), $sformatf("rnd_k%0d_b%0d", k, b), 1'(b));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/aes_inv_cipher_ctrl.md
Name: aes_inv_cipher_ctrl

Overview:
Iterative AES-128 inverse-cipher sequencer. It executes one decryption round per clock on a single shared round datapath, which contains one InvMixColumns instance plus InvShiftRows, InvSubBytes and AddRoundKey. It fetches round keys by index from an external key store. It accepts a ciphertext over a valid/ready handshake and returns the plaintext over a second valid/ready handshake. It sits between the key-expansion store and the decryption result path.

Parameters:
NR, 10, number of rounds (10 for AES-128); the round counter is sized to clog2(NR+1).
DW, 128, state/block width; fixed at 128, present for documentation and checks only.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
reset_n  input  1  asynchronous active-low reset.
in_valid  input  1  ciphertext offered.
in_ready  output  1  controller can accept a ciphertext.
in_data  input  128  ciphertext; byte 0 is in bits [127:120], column-major as in the round datapath.
rk_idx  output  clog2(NR+1)  round-key index requested this cycle.
rk_data  input  128  round key for rk_idx; combinational, same-cycle response.
out_valid  output  1  plaintext available.
out_ready  input  1  consumer accepts the plaintext.
out_data  output  128  plaintext.
busy  output  1  high in ROUND or DONE.

Behaviour:
- Reset (async assert, sync release): state=IDLE, state_q=0, round_q=0, out_valid=0, out_data=0, in_ready=0 during reset, busy=0.
- FSM states are IDLE, ROUND and DONE.
- IDLE:
  - in_ready=1 and rk_idx=NR.
  - When in_valid&&in_ready: state_q <= in_data ^ rk_data (initial AddRoundKey with key NR), round_q <= NR-1, go to ROUND.
- ROUND:
  - in_ready=0 and rk_idx=round_q.
  - Every cycle: t = InvSubBytes(InvShiftRows(state_q)) ^ rk_data.
  - If round_q!=0: state_q <= InvMixColumns(t), round_q <= round_q-1.
  - If round_q==0 (final round): state_q <= t, out_data <= t, out_valid <= 1, go to DONE. InvMixColumns is bypassed in this round.
- DONE:
  - out_valid=1; out_data is held stable; in_ready=0; rk_idx=0 (don't-care).
  - When out_ready is high: out_valid <= 0, go to IDLE.
  - out_data keeps its last value after the handshake; it is not cleared.
- Latency: out_valid rises exactly NR cycles after the accept edge (10 for AES-128). Throughput is one block per NR+2 cycles with out_ready held high.
- Back-pressure: out_ready low holds DONE indefinitely with no loss or corruption. in_valid is ignored outside IDLE.
- in_data is sampled only at the accept edge; later changes have no effect.
- rk_data must be a combinational function of rk_idx. The controller never registers rk_idx-to-key latency.
- round_q never wraps. The ROUND-exit test is round_q==0, so no decrement below 0 occurs.
- Reset mid-operation (any state): immediate return to reset values. The in-flight block is discarded and no partial out_valid pulse is produced.
- in_valid and out_ready may both be high in DONE. The out handshake completes; the new block is accepted no earlier than the following cycle (IDLE).
- All arithmetic is GF(2^8)/XOR only. There are no carries or width extension.

Decomposition:
- Package aes_pkg holds:
  - NR_128=10 and the block width constant 128.
  - The FSM enum {IDLE, ROUND, DONE}.
  - The InvSbox table as a constant function.
- Sub-module aes_inv_round is purely combinational. Its inputs are state, rk and final flag; its output is next state. It implements InvShiftRows, InvSubBytes, AddRoundKey and, when final=0, the existing InvMixColumns instance. The controller holds only the FSM, registers and key indexing.

Test Plan:
- FIPS-197 C.1: key store loaded from key 000102030405060708090a0b0c0d0e0f; in_data=69c4e0d86a7b0430d8cdb78070b4c55a. Required: out_data=00112233445566778899aabbccddeeff, with out_valid rising 10 cycles after the accept edge.
- rk_idx sequence check: rk_idx=10 at accept, then 9,8,…,1,0 on successive ROUND cycles. Key store returns all-zero keys and in_data=0. Required: output equals the software model of the zero-key inverse cipher.
- Back-pressure: hold out_ready=0 for 20 cycles after out_valid. Required: out_valid and out_data stable, in_ready=0 throughout; release gives a one-cycle handshake, then in_ready=1 on the next cycle.
- Back-to-back: in_valid held high with two ciphertexts (C.1 block, then zero block) and out_ready=1. Required: both plaintexts correct, second accept exactly NR+2 cycles after the first.
- Reset mid-operation: assert reset_n=0 while round_q=5. Required: out_valid=0, busy=0, out_data=0 asynchronously; after release, in_ready=1 and a fresh C.1 decrypt is correct.
- in_valid toggled during ROUND with different in_data. Required: no second accept and no change to the in-flight result.
